dmem_arbiter: RTL and testbench
===============================

# dmem_arbiter

Two-master arbiter that shares the single data memory port (daddr/dwdata/we/drdata) between the CPU load/store path (m0) and a secondary requester such as a DMA or debug loader (m1). Sits between the masters and dmem. Grants at most one access per cycle, with round-robin fairness and a bounded burst lock, and returns registered read data to the granted master.

## Interface
- AW, 32: address width.
- DW, 32: data width.
- MAX_BURST, 4: maximum consecutive granted beats one master may hold while the other is requesting; range 1..15.
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- m0_req  in  1  access request; held with addr/wdata/we stable until m0_gnt.
- m0_addr  in  AW  byte address.
- m0_wdata  in  DW  write data.
- m0_we  in  4  byte write enables; 0 means read.
- m0_gnt  out  1  access accepted this cycle.
- m0_rdata  out  DW  read data.
- m0_rvalid  out  1  m0_rdata valid; one-cycle pulse.
- m1_*  (same seven signals as m0_*).
- daddr  out  AW  to dmem.
- dwdata  out  DW  to dmem.
- we  out  4  to dmem; 0 unless a granted write.
- drdata  in  DW  from dmem, combinational read of daddr.

## Operation
- State: owner (NONE/M0/M1), beat counter cnt (4 bits), round-robin pointer rr (next preferred master).
- Grant decision is combinational from registered state and current reqs:
  - No req: no grant.
  - One master requesting: grant it.
  - Both requesting, owner NONE: grant rr.
  - Both requesting, owner Mx with cnt < MAX_BURST: grant Mx.
  - Both requesting, owner Mx with cnt == MAX_BURST: grant the other master.
- On the clock edge:
  - Granted master becomes owner. cnt = cnt+1 if owner unchanged, else 1. cnt saturates at MAX_BURST while the other master is idle, and is held at 1 after a switch.
  - rr = the non-granted master.
  - With no grant: owner = NONE, cnt = 0, rr unchanged.
- dmem mux: granted master's addr/wdata/we drive daddr/dwdata/we. With no grant: daddr = 0, dwdata = 0, we = 0.
- Read return: on a granted read (we==0), drdata is registered into that master's rdata and its rvalid is asserted for the following cycle. rdata holds its value otherwise.
- Writes produce no rvalid.
- Only one of m0_gnt and m1_gnt is ever asserted at a time. A write and a read can never collide.

## Timing
- Reset (rst low, asynchronous) clears everything:
  - owner = NONE, cnt = 0, rr = M0.
  - m0/m1_rvalid = 0 and m0/m1_rdata = 0.
  - m0/m1_gnt forced 0, we = 0, daddr = 0, dwdata = 0.
- Reset mid-access: any pending rvalid is dropped and is not reissued after release.
- First grant possible in the first cycle rst is high.
- Grant latency: 0 cycles when uncontended.
- Worst-case wait for a contended master: MAX_BURST cycles.
- Read latency: rvalid exactly 1 cycle after the gnt cycle. Back-to-back reads give rvalid every cycle.
- Dropping req without a gnt is illegal; the bench treats it as a protocol error.

## Structure
- Shared package dmem_arb_pkg holds:
  - owner_t enum {OWN_NONE, OWN_M0, OWN_M1}.
  - MAX_BURST default.
  - Master-index constants.
- One sub-module, dmem_arb_fsm: owns owner/cnt/rr and emits the one-hot grant.
- Top level holds the request mux, the read-data registers and the rvalid flops.

## Test plan
- Reset release, no reqs: all outputs 0 and we=0 for 5 cycles. Assert rst low mid-read → rvalid stays 0 after release.
- m0 alone reads 0x100 with dmem[0x100]=0xDEADBEEF → m0_gnt same cycle, m0_rvalid next cycle, m0_rdata=0xDEADBEEF. m1 signals untouched.
- Both request continuously from reset, MAX_BURST=4 → grant sequence M0×4, M1×4, M0×4. Neither master waits more than 4 cycles.
- Both assert req in the same cycle from idle after m1 was the last served → m0 granted first (rr).
- m1 writes 0xCAFEF00D to 0x200 with we=4'hF while m0 is idle, then m0 reads 0x200 → we=4'hF only in m1's gnt cycle, m0_rdata=0xCAFEF00D. A write with we=4'h3 updates only the low half.
- m0 streams 10 back-to-back reads while m1 is idle → 10 consecutive grants (cnt saturates, no forced yield) and 10 consecutive rvalid pulses in order.

Source files
------------

// File: rtl/dmem_arb_pkg.sv
// Shared types and constants for the two-master data-memory arbiter.
package dmem_arb_pkg;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_M0   = 2'd1,
        OWN_M1   = 2'd2
    } owner_t;

    localparam int MAX_BURST_DEF = 4;
    localparam int CNT_W         = 4;
    localparam int IDX_M0        = 0;
    localparam int IDX_M1        = 1;
    localparam int NUM_M         = 2;

endpackage

// File: rtl/dmem_arb_fsm.sv
// Ownership / burst-count / round-robin state and the one-hot grant decision.
module dmem_arb_fsm
    import dmem_arb_pkg::*;
#(
    parameter int MAX_BURST = MAX_BURST_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [NUM_M-1:0] req,
    output logic [NUM_M-1:0] gnt
);

    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_BURST);

    owner_t           owner_reg, owner_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic             rr_reg, rr_next;   // 0: prefer M0, 1: prefer M1

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            owner_reg <= OWN_NONE;
            cnt_reg   <= '0;
            rr_reg    <= 1'b0;
        end else begin
            owner_reg <= owner_next;
            cnt_reg   <= cnt_next;
            rr_reg    <= rr_next;
        end
    end

    always_comb begin
        gnt        = '0;
        owner_next = OWN_NONE;
        cnt_next   = '0;
        rr_next    = rr_reg;

        unique case (req)
            2'b01:   gnt = 2'b01;
            2'b10:   gnt = 2'b10;
            2'b11: begin
                case (owner_reg)
                    OWN_M0:  gnt = (cnt_reg < MAX_CNT) ? 2'b01 : 2'b10;
                    OWN_M1:  gnt = (cnt_reg < MAX_CNT) ? 2'b10 : 2'b01;
                    default: gnt = rr_reg ? 2'b10 : 2'b01;
                endcase
            end
            default: gnt = 2'b00;
        endcase

        // No grant may escape while reset is held, even combinationally.
        if (!rst) begin
            gnt = '0;
        end

        if (gnt[IDX_M0]) begin
            owner_next = OWN_M0;
            rr_next    = 1'b1;
            if (owner_reg == OWN_M0) begin
                cnt_next = (cnt_reg >= MAX_CNT) ? MAX_CNT : cnt_reg + 1'b1;
            end else begin
                cnt_next = CNT_W'(1);
            end
        end else if (gnt[IDX_M1]) begin
            owner_next = OWN_M1;
            rr_next    = 1'b0;
            if (owner_reg == OWN_M1) begin
                cnt_next = (cnt_reg >= MAX_CNT) ? MAX_CNT : cnt_reg + 1'b1;
            end else begin
                cnt_next = CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Shares one data-memory port between two masters: grant FSM, request mux,
// and per-master registered read return.
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int AW        = 32,
    parameter int DW        = 32,
    parameter int MAX_BURST = MAX_BURST_DEF
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          m0_req,
    input  logic [AW-1:0] m0_addr,
    input  logic [DW-1:0] m0_wdata,
    input  logic [3:0]    m0_we,
    output logic          m0_gnt,
    output logic [DW-1:0] m0_rdata,
    output logic          m0_rvalid,
    input  logic          m1_req,
    input  logic [AW-1:0] m1_addr,
    input  logic [DW-1:0] m1_wdata,
    input  logic [3:0]    m1_we,
    output logic          m1_gnt,
    output logic [DW-1:0] m1_rdata,
    output logic          m1_rvalid,
    output logic [AW-1:0] daddr,
    output logic [DW-1:0] dwdata,
    output logic [3:0]    we,
    input  logic [DW-1:0] drdata
);

    logic [NUM_M-1:0] req;
    logic [NUM_M-1:0] gnt;
    logic [AW-1:0]    addr_arr   [NUM_M];
    logic [DW-1:0]    wdata_arr  [NUM_M];
    logic [3:0]       we_arr     [NUM_M];
    logic             rvalid_reg [NUM_M];
    logic [DW-1:0]    rdata_reg  [NUM_M];

    assign req[IDX_M0]       = m0_req;
    assign req[IDX_M1]       = m1_req;
    assign addr_arr[IDX_M0]  = m0_addr;
    assign addr_arr[IDX_M1]  = m1_addr;
    assign wdata_arr[IDX_M0] = m0_wdata;
    assign wdata_arr[IDX_M1] = m1_wdata;
    assign we_arr[IDX_M0]    = m0_we;
    assign we_arr[IDX_M1]    = m1_we;

    dmem_arb_fsm #(
        .MAX_BURST(MAX_BURST)
    ) u_fsm (
        .clk(clk),
        .rst(rst),
        .req(req),
        .gnt(gnt)
    );

    assign m0_gnt    = gnt[IDX_M0];
    assign m1_gnt    = gnt[IDX_M1];
    assign m0_rvalid = rvalid_reg[IDX_M0];
    assign m1_rvalid = rvalid_reg[IDX_M1];
    assign m0_rdata  = rdata_reg[IDX_M0];
    assign m1_rdata  = rdata_reg[IDX_M1];

    // Grant is one-hot, so a priority mux is enough; idle drives all zeros.
    always_comb begin
        daddr  = '0;
        dwdata = '0;
        we     = '0;
        if (gnt[IDX_M0]) begin
            daddr  = addr_arr[IDX_M0];
            dwdata = wdata_arr[IDX_M0];
            we     = we_arr[IDX_M0];
        end else if (gnt[IDX_M1]) begin
            daddr  = addr_arr[IDX_M1];
            dwdata = wdata_arr[IDX_M1];
            we     = we_arr[IDX_M1];
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < NUM_M; gi++) begin : g_rd
            logic rd_hit;
            assign rd_hit = gnt[gi] && (we_arr[gi] == 4'h0);

            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    rvalid_reg[gi] <= 1'b0;
                    rdata_reg[gi]  <= '0;
                end else begin
                    rvalid_reg[gi] <= rd_hit;
                    if (rd_hit) begin
                        rdata_reg[gi] <= drdata;
                    end
                end
            end
        end
    endgenerate

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed scoreboard bench for dmem_arbiter with a behavioural byte-enabled dmem.
module tb_dmem_arbiter;

    logic        clk;
    logic        rst;
    logic        m0_req, m1_req;
    logic [31:0] m0_addr, m1_addr, m0_wdata, m1_wdata;
    logic [3:0]  m0_we, m1_we;
    logic        m0_gnt, m1_gnt, m0_rvalid, m1_rvalid;
    logic [31:0] m0_rdata, m1_rdata;
    logic [31:0] daddr, dwdata, drdata;
    logic [3:0]  we;

    logic [31:0] mem     [256];
    logic [31:0] ref_mem [256];
    logic [31:0] q0 [$];
    logic [31:0] q1 [$];
    int          checks   = 0;
    int          failures = 0;

    dmem_arbiter #(
        .AW(32),
        .DW(32),
        .MAX_BURST(4)
    ) dut (
        .clk(clk), .rst(rst),
        .m0_req(m0_req), .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_we(m0_we),
        .m0_gnt(m0_gnt), .m0_rdata(m0_rdata), .m0_rvalid(m0_rvalid),
        .m1_req(m1_req), .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_we(m1_we),
        .m1_gnt(m1_gnt), .m1_rdata(m1_rdata), .m1_rvalid(m1_rvalid),
        .daddr(daddr), .dwdata(dwdata), .we(we), .drdata(drdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign drdata = mem[daddr[9:2]];

    always @(posedge clk) begin
        for (int b = 0; b < 4; b++) begin
            if (we[b]) mem[daddr[9:2]][8*b +: 8] <= dwdata[8*b +: 8];
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
        end
    endtask

    // One clock cycle: check last cycle's read return, this cycle's grant and
    // dmem drive, then record what this cycle should produce.
    task automatic step(input logic eg0, input logic eg1, input string tag);
        logic [31:0] e;
        logic [31:0] ea, ed;
        logic [3:0]  ew;
        @(negedge clk);
        chk({tag, ":m0_rvalid"}, {31'd0, m0_rvalid}, {31'd0, q0.size() > 0});
        if (q0.size() > 0) begin
            e = q0.pop_front();
            if (m0_rvalid) chk({tag, ":m0_rdata"}, m0_rdata, e);
        end
        chk({tag, ":m1_rvalid"}, {31'd0, m1_rvalid}, {31'd0, q1.size() > 0});
        if (q1.size() > 0) begin
            e = q1.pop_front();
            if (m1_rvalid) chk({tag, ":m1_rdata"}, m1_rdata, e);
        end
        chk({tag, ":m0_gnt"}, {31'd0, m0_gnt}, {31'd0, eg0});
        chk({tag, ":m1_gnt"}, {31'd0, m1_gnt}, {31'd0, eg1});
        ea = '0; ed = '0; ew = '0;
        if (eg0) begin
            ea = m0_addr; ed = m0_wdata; ew = m0_we;
        end else if (eg1) begin
            ea = m1_addr; ed = m1_wdata; ew = m1_we;
        end
        chk({tag, ":daddr"}, daddr, ea);
        chk({tag, ":dwdata"}, dwdata, ed);
        chk({tag, ":we"}, {28'd0, we}, {28'd0, ew});
        if (eg0 || eg1) begin
            if (ew == 4'h0) begin
                if (eg0) q0.push_back(ref_mem[ea[9:2]]);
                else     q1.push_back(ref_mem[ea[9:2]]);
            end else begin
                for (int b = 0; b < 4; b++) begin
                    if (ew[b]) ref_mem[ea[9:2]][8*b +: 8] = ed[8*b +: 8];
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        for (int i = 0; i < 256; i++) begin
            mem[i]     = 32'h0;
            ref_mem[i] = 32'h0;
        end
        mem[8'h40] = 32'hDEADBEEF; ref_mem[8'h40] = 32'hDEADBEEF;
        for (int i = 0; i < 10; i++) begin
            mem[8'hC0 + i]     = 32'hA5000000 + i * 32'h01010101;
            ref_mem[8'hC0 + i] = 32'hA5000000 + i * 32'h01010101;
        end

        rst = 1'b0;
        m0_req = 1'b1; m0_addr = 32'h100; m0_wdata = '0; m0_we = 4'h0;
        m1_req = 1'b0; m1_addr = 32'h0;   m1_wdata = '0; m1_we = 4'h0;

        // Held in reset with a request pending: everything stays zero.
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst:m0_gnt_forced", {31'd0, m0_gnt}, 32'd0);
        chk("rst:daddr", daddr, 32'd0);
        chk("rst:we", {28'd0, we}, 32'd0);
        chk("rst:m0_rdata", m0_rdata, 32'd0);
        chk("rst:m1_rdata", m1_rdata, 32'd0);
        m0_req = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;

        for (int i = 0; i < 5; i++) step(1'b0, 1'b0, "idle");

        // m0 single read, uncontended.
        m0_req = 1'b1; m0_addr = 32'h100; m0_we = 4'h0;
        step(1'b1, 1'b0, "rd100");
        m0_req = 1'b0;
        step(1'b0, 1'b0, "rd100_ret");
        chk("rd100:m1_rdata_untouched", m1_rdata, 32'd0);

        // m1 full write, m0 reads it back, m1 partial write.
        m1_req = 1'b1; m1_addr = 32'h200; m1_wdata = 32'hCAFEF00D; m1_we = 4'hF;
        step(1'b0, 1'b1, "wr200");
        m1_req = 1'b0;
        m0_req = 1'b1; m0_addr = 32'h200; m0_we = 4'h0;
        step(1'b1, 1'b0, "rd200");
        m0_req = 1'b0;
        step(1'b0, 1'b0, "rd200_ret");
        m1_req = 1'b1; m1_addr = 32'h200; m1_wdata = 32'h12345678; m1_we = 4'h3;
        step(1'b0, 1'b1, "wr200_lo");
        m1_req = 1'b0; m1_we = 4'h0; m1_wdata = '0;
        step(1'b0, 1'b0, "idle2");

        // m1 served last, now both request from idle: rr picks m0, then bursts of 4.
        m0_req = 1'b1; m0_addr = 32'h200; m0_we = 4'h0;
        m1_req = 1'b1; m1_addr = 32'h100; m1_we = 4'h0;
        for (int i = 0; i < 12; i++) begin
            step(((i / 4) % 2) == 0, ((i / 4) % 2) == 1, $sformatf("burst%0d", i));
        end
        m0_req = 1'b0;
        step(1'b0, 1'b1, "burst_tail");
        m1_req = 1'b0;
        step(1'b0, 1'b0, "burst_ret");

        // m0 streams 10 reads alone: no forced yield, rvalid every cycle.
        m0_req = 1'b1; m0_we = 4'h0;
        for (int i = 0; i < 10; i++) begin
            m0_addr = 32'h300 + 32'(4 * i);
            step(1'b1, 1'b0, $sformatf("stream%0d", i));
        end
        m0_req = 1'b0;
        step(1'b0, 1'b0, "stream_ret");

        // Reset while a read return is in flight drops it for good.
        m0_req = 1'b1; m0_addr = 32'h100; m0_we = 4'h0;
        step(1'b1, 1'b0, "rstmid_rd");
        m0_req = 1'b0;
        chk("rstmid:rvalid_before", {31'd0, m0_rvalid}, 32'd1);
        rst = 1'b0;
        #1;
        chk("rstmid:rvalid_cleared", {31'd0, m0_rvalid}, 32'd0);
        chk("rstmid:rdata_cleared", m0_rdata, 32'd0);
        q0.delete();
        @(posedge clk);
        #1;
        rst = 1'b1;
        step(1'b0, 1'b0, "rstmid_after0");
        step(1'b0, 1'b0, "rstmid_after1");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
